// File: rtl/pc_next_unit_if.sv
// Fetch-side bus of the PC stage: redirect inputs, imem handshake, PC outputs.
// Carries align_err_o only when PC_ALIGN_CHECK_EN is defined.
interface pc_next_unit_if;
    logic [31:0] shifted_offset_i;
    logic        branch_i;
    logic        jump_i;
    logic [25:0] jump_addr_i;
    logic        jr_i;
    logic [31:0] jr_addr_i;
    logic        imem_ack_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        imem_req_o;
    logic        redirect_pending_o;
`ifdef PC_ALIGN_CHECK_EN
    logic        align_err_o;
`endif

    modport master (
        output shifted_offset_i, branch_i, jump_i, jump_addr_i,
        output jr_i, jr_addr_i, imem_ack_i,
`ifdef PC_ALIGN_CHECK_EN
        input  align_err_o,
`endif
        input  pc_o, pc_plus4_o, imem_req_o, redirect_pending_o
    );

    modport slave (
        input  shifted_offset_i, branch_i, jump_i, jump_addr_i,
        input  jr_i, jr_addr_i, imem_ack_i,
`ifdef PC_ALIGN_CHECK_EN
        output align_err_o,
`endif
        output pc_o, pc_plus4_o, imem_req_o, redirect_pending_o
    );
endinterface

// File: rtl/pc_next_unit.sv
// PC stage: target generation, PC register, redirect capture across fetch stalls.
// Optional PC_ALIGN_CHECK_EN: flags and word-aligns misaligned JR targets.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_W     = 32
) (
    input logic          clk_i,
    input logic          rst_i,
    pc_next_unit_if.slave bus
);

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic [PC_W-1:0] pend, pend_nxt;
    logic [PC_W-1:0] pc_plus4, btarget, jtarget, jrtarget, win;
    logic            redirect;

    assign pc_plus4 = pc + PC_W'(4);
    assign btarget  = pc_plus4 + bus.shifted_offset_i;
    assign jtarget  = {pc_plus4[PC_W-1:PC_W-4], bus.jump_addr_i, 2'b00};
    assign redirect = bus.jr_i | bus.jump_i | bus.branch_i;

`ifdef PC_ALIGN_CHECK_EN
    logic align_err;
    logic jr_bad;

    assign jrtarget = {bus.jr_addr_i[PC_W-1:2], 2'b00};
    assign jr_bad   = (state != BOOT) && bus.jr_i && (bus.jr_addr_i[1:0] != 2'b00);

    // Sticky until reset so software sees any misaligned JR.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       align_err <= 1'b0;
        else if (jr_bad) align_err <= 1'b1;
    end

    assign bus.align_err_o = align_err;
`else
    assign jrtarget = bus.jr_addr_i;
`endif

    always_comb begin
        win = pc_plus4;
        priority case (1'b1)
            bus.jr_i:     win = jrtarget;
            bus.jump_i:   win = jtarget;
            bus.branch_i: win = btarget;
            default:      win = pc_plus4;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        pend_nxt  = pend;
        unique case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (bus.imem_ack_i) begin
                    pc_nxt = redirect ? win : pc_plus4;
                end else if (redirect) begin
                    pend_nxt  = win;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // A redirect seen on the ack cycle is newer than the pending one.
                if (bus.imem_ack_i) begin
                    pc_nxt    = redirect ? win : pend;
                    pend_nxt  = '0;
                    state_nxt = RUN;
                end else if (redirect) begin
                    pend_nxt = win;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= BOOT;
            pc    <= RESET_PC;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            pend  <= pend_nxt;
        end
    end

    assign bus.pc_o               = pc;
    assign bus.pc_plus4_o         = pc_plus4;
    assign bus.imem_req_o         = (state != BOOT);
    assign bus.redirect_pending_o = (state == HOLD);

endmodule
